core_seq_ctrl: RTL and testbench

//  Hardware sequencer that drives the 34-bit inst bus of core for one conv layer (all kij), replacing bench-driven stepping.
//  Per kij: xmem weights->L0->PEs, activations->L0->IFIFO, execute, drain OFIFO psums into pmem; sits between host start/done and core.inst.

---
 rtl/core_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Layer sequencer for core: for each kernel position it loads weights, stages
// activations, executes and drains psums into pmem by driving the instruction bus.
module core_seq_ctrl #(
    parameter int            COL      = 8,
    parameter int            ROW      = 8,
    parameter int            LEN_KIJ  = 9,
    parameter int            LEN_NIJ  = 36,
    parameter int            LEN_ONIJ = 16,
    parameter int            GAP      = 10,
    parameter int            AW       = 11,
    parameter logic [AW-1:0] WBASE    = 11'h400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ofifo_valid,
    output logic [2*AW+11:0] inst,
    output logic             busy,
    output logic             done,
    output logic [3:0]       kij_idx
);

    localparam int IW = 2 * AW + 12;
    localparam int CW = 8;

    localparam logic [AW-1:0] COL_A  = AW'(COL);
    localparam logic [AW-1:0] ONIJ_A = AW'(LEN_ONIJ);

    localparam logic [6:0] STB_NONE     = 7'b000_0000;
    localparam logic [6:0] STB_OFIFO_RD = 7'b100_0000;
    localparam logic [6:0] STB_IFIFO_WR = 7'b010_0000;
    localparam logic [6:0] STB_IFIFO_RD = 7'b001_0000;
    localparam logic [6:0] STB_L0_RD    = 7'b000_1000;
    localparam logic [6:0] STB_L0_WR    = 7'b000_0100;
    localparam logic [6:0] STB_EXECUTE  = 7'b000_0010;
    localparam logic [6:0] STB_LOAD     = 7'b000_0001;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_L0   = 4'd1,
        W_LOAD = 4'd2,
        W_GAP  = 4'd3,
        A_L0   = 4'd4,
        A_FIFO = 4'd5,
        EXEC   = 4'd6,
        DRAIN  = 4'd7,
        NEXT   = 4'd8,
        FIN    = 4'd9
    } state_e;

    // Last counter value of the fixed-length phases.
    function automatic logic [CW-1:0] phase_last(input state_e st);
        logic [CW-1:0] last;
        case (st)
            W_L0, W_LOAD:  last = CW'(COL - 1);
            W_GAP:         last = CW'(GAP - 1);
            A_L0, A_FIFO:  last = CW'(LEN_NIJ - 1);
            EXEC:          last = CW'(LEN_NIJ + ROW + COL - 1);
            default:       last = {CW{1'b0}};
        endcase
        return last;
    endfunction

    function automatic state_e phase_succ(input state_e st);
        state_e nxt;
        case (st)
            W_L0:    nxt = W_LOAD;
            W_LOAD:  nxt = W_GAP;
            W_GAP:   nxt = A_L0;
            A_L0:    nxt = A_FIFO;
            A_FIFO:  nxt = EXEC;
            EXEC:    nxt = DRAIN;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // Instruction word for one cycle; addresses wrap modulo 2^AW.
    function automatic logic [IW-1:0] decode(input state_e st, input logic [CW-1:0] cnt,
                                             input logic [3:0] kij, input logic pop);
        logic          cen_p;
        logic          cen_x;
        logic [AW-1:0] a_p;
        logic [AW-1:0] a_x;
        logic [6:0]    stb;
        logic [AW-1:0] cnt_a;
        logic [AW-1:0] kij_a;
        cen_p = 1'b1;
        cen_x = 1'b1;
        a_p   = {AW{1'b0}};
        a_x   = {AW{1'b0}};
        stb   = STB_NONE;
        cnt_a = AW'(cnt);
        kij_a = AW'(kij);
        case (st)
            W_L0: begin
                cen_x = 1'b0;
                a_x   = WBASE + kij_a * COL_A + cnt_a;
                stb   = STB_L0_WR;
            end
            W_LOAD:  stb = STB_LOAD | STB_L0_RD;
            A_L0: begin
                cen_x = 1'b0;
                a_x   = cnt_a;
                stb   = STB_L0_WR;
            end
            A_FIFO:  stb = STB_L0_RD | STB_IFIFO_WR;
            EXEC:    stb = STB_EXECUTE | STB_IFIFO_RD;
            DRAIN: begin
                if (pop) begin
                    cen_p = 1'b0;
                    a_p   = kij_a * ONIJ_A + cnt_a;
                    stb   = STB_OFIFO_RD;
                end else begin
                    stb   = STB_NONE;
                end
            end
            default: stb = STB_NONE;
        endcase
        // WEN_p follows CEN_p: every pmem access issued here is a write.
        return {1'b0, cen_p, cen_p, a_p, cen_x, 1'b1, a_x, stb};
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    kij_q, kij_d;
    logic          pop_q, pop_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] pops_s;
    logic          last_s;

    // Next-state logic; the registered outputs are decoded from the next state so
    // inst always describes the phase cycle the FSM is in. In DRAIN, cnt counts pops
    // already issued and ofifo_valid sampled at an edge yields a pop the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        pop_d   = 1'b0;
        last_s  = (cnt_q == phase_last(state_q));
        pops_s  = cnt_q + CW'(pop_q);
        if (abort) begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
            kij_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = W_L0;
                        cnt_d   = {CW{1'b0}};
                        kij_d   = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                W_L0, W_LOAD, W_GAP, A_L0, A_FIFO, EXEC: begin
                    if (last_s) begin
                        state_d = phase_succ(state_q);
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (pops_s == CW'(LEN_ONIJ)) begin
                        state_d = NEXT;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d   = pops_s;
                    end
                end
                NEXT: begin
                    cnt_d = {CW{1'b0}};
                    if (kij_q == 4'(LEN_KIJ - 1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = W_L0;
                        kij_d   = kij_q + 4'd1;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                    kij_d   = 4'd0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                    kij_d   = 4'd0;
                end
            endcase
            if (state_d == DRAIN) begin
                pop_d = ofifo_valid;
            end else begin
                pop_d = 1'b0;
            end
        end
        inst_d = decode(state_d, cnt_d, kij_d, pop_d);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            kij_q   <= 4'd0;
            pop_q   <= 1'b0;
            inst_q  <= decode(IDLE, {CW{1'b0}}, 4'd0, 1'b0);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            pop_q   <= pop_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst    = inst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign kij_idx = kij_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: walks whole layers cycle by cycle against
// hand-built instruction words, plus start/abort/reset corner cases.
module tb_core_seq_ctrl;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    localparam logic [6:0] S_NONE  = 7'b000_0000;
    localparam logic [6:0] S_ORD   = 7'b100_0000;
    localparam logic [6:0] S_FWR   = 7'b010_0000;
    localparam logic [6:0] S_FRD   = 7'b001_0000;
    localparam logic [6:0] S_L0RD  = 7'b000_1000;
    localparam logic [6:0] S_L0WR  = 7'b000_0100;
    localparam logic [6:0] S_EXEC  = 7'b000_0010;
    localparam logic [6:0] S_LOAD  = 7'b000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pwr = 0;
    logic [10:0] last_ap = 11'd0;

    core_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done),
        .kij_idx    (kij_idx)
    );

    always #5 clk = ~clk;

    // pmem write monitor
    always @(negedge clk) begin
        if (reset && inst[32] == 1'b0 && inst[31] == 1'b0) begin
            n_pwr   <= n_pwr + 1;
            last_ap <= inst[30:20];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] mk(input logic cen_x, input logic [10:0] a_x,
                                       input logic cen_p, input logic [10:0] a_p,
                                       input logic [6:0] stb);
        return {1'b0, cen_p, cen_p, a_p, cen_x, 1'b1, a_x, stb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One kij pass starting from the cycle before W_L0.
    // mode 0: ofifo_valid toggles starting low; mode 1: held high.
    // cut 1: abort after 10 EXEC cycles; cut 2: reset low after 5 drain pops.
    task automatic run_kij(input int k, input int mode, input int cut);
        logic [10:0] a;
        logic        v;
        int          pops;
        int          j;
        int          w0;
        for (int c = 0; c < 8; c++) begin
            step();
            start = 1'b0;
            a = 11'h400 + 11'(k * 8 + c);
            check_eq("w_l0", inst, mk(1'b0, a, 1'b1, 11'd0, S_L0WR));
            if (c == 0) check_eq("kij_idx", kij_idx, k);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("w_load", inst, mk(1'b1, 11'd0, 1'b1, 11'd0, S_LOAD | S_L0RD));
        end
        for (int c = 0; c < 10; c++) begin
            start = (k == 1 && c == 3) ? 1'b1 : 1'b0;
            step();
            start = 1'b0;
            check_eq("w_gap", inst, INST_IDLE);
        end
        for (int c = 0; c < 36; c++) begin
            step();
            check_eq("a_l0", inst, mk(1'b0, 11'(c), 1'b1, 11'd0, S_L0WR));
        end
        for (int c = 0; c < 36; c++) begin
            step();
            check_eq("a_fifo", inst, mk(1'b1, 11'd0, 1'b1, 11'd0, S_L0RD | S_FWR));
        end
        for (int c = 0; c < 52; c++) begin
            step();
            check_eq("exec", inst, mk(1'b1, 11'd0, 1'b1, 11'd0, S_EXEC | S_FRD));
            if (cut == 1 && c == 9) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check_eq("abort_inst", inst, INST_IDLE);
                check_eq("abort_busy", busy, 1'b0);
                check_eq("abort_kij", kij_idx, 4'd0);
                check_eq("abort_done", done, 1'b0);
                return;
            end
        end
        w0 = n_pwr;
        pops = 0;
        j = 0;
        while (pops < 16 && j < 200) begin
            v = (mode == 1) ? 1'b1 : 1'(j % 2);
            ofifo_valid = v;
            step();
            if (v) begin
                check_eq("drain_pop", inst, mk(1'b1, 11'd0, 1'b0, 11'(k * 16 + pops), S_ORD));
                pops++;
            end else begin
                check_eq("drain_stall", inst, INST_IDLE);
            end
            if (cut == 2 && pops == 5) begin
                reset = 1'b0;
                #1;
                check_eq("rst_inst", inst, INST_IDLE);
                check_eq("rst_busy", busy, 1'b0);
                check_eq("rst_kij", kij_idx, 4'd0);
                ofifo_valid = 1'b0;
                return;
            end
            j++;
        end
        check_eq("drain_pops", pops, 16);
        ofifo_valid = 1'b0;
        step();
        check_eq("next_inst", inst, INST_IDLE);
        check_eq("next_busy", busy, 1'b1);
        check_eq("pmem_writes", n_pwr - w0, 16);
        check_eq("pmem_last", last_ap, 11'(k * 16 + 15));
    endtask

    task automatic run_layer(input int mode);
        start = 1'b1;
        for (int k = 0; k < 9; k++) run_kij(k, mode, 0);
        step();
        check_eq("fin_done", done, 1'b1);
        check_eq("fin_inst", inst, INST_IDLE);
        check_eq("layer_last_ap", last_ap, 11'd143);
        step();
        check_eq("idle_done", done, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_kij", kij_idx, 4'd0);
        step();
        check_eq("done_single", done, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ofifo_valid = 1'b0;
        #23;
        check_eq("reset_inst", inst, INST_IDLE);
        check_eq("reset_kij", kij_idx, 4'd0);
        check_eq("reset_done", done, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("idle_hold_inst", inst, INST_IDLE);
            check_eq("idle_hold_busy", busy, 1'b0);
        end

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_busy", busy, 1'b0);
        check_eq("start_abort_inst", inst, INST_IDLE);

        run_layer(0);

        start = 1'b1;
        for (int k = 0; k < 3; k++) run_kij(k, 1, 0);
        run_kij(3, 1, 1);
        step();
        check_eq("post_abort_busy", busy, 1'b0);
        run_layer(1);

        start = 1'b1;
        run_kij(0, 1, 2);
        step();
        check_eq("rst_hold_inst", inst, INST_IDLE);
        reset = 1'b1;
        step();
        check_eq("rst_rel_busy", busy, 1'b0);
        check_eq("rst_rel_inst", inst, INST_IDLE);
        run_layer(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
